// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the 3-read/1-write register-file controller
// Contents: rf_addr_t, RF_DEPTH, RF_ZERO_REG, rf_state_e.
package rf_pkg;

  localparam int RF_DEPTH = 32;

  typedef logic [4:0] rf_addr_t;

  localparam rf_addr_t RF_ZERO_REG = 5'd0;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_lane.sv
// rtl/rf_read_lane.sv - one read port: address/hit capture and zero/bypass/RAM output select
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   r_addr_i        read address issued in cycle t
//   init_i          controller is in the clear sweep during cycle t
//   we_eff_i        effective (gated) write enable in cycle t
//   w_addr_i        write address in cycle t
//   byp_data_i      shared registered copy of the cycle-t write data
//   ram_dout_i      RAM read data for this port, valid in cycle t+1
//   r_data_o        read result in cycle t+1
module rf_read_lane
  import rf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rf_addr_t         r_addr_i,
  input  logic             init_i,
  input  logic             we_eff_i,
  input  rf_addr_t         w_addr_i,
  input  logic [WIDTH-1:0] byp_data_i,
  input  logic [WIDTH-1:0] ram_dout_i,
  output logic [WIDTH-1:0] r_data_o
);

  rf_addr_t addr_q;
  logic     hit_q;
  logic     hit_d;
  logic     init_q;

  // The RAM returns old data when read and written in the same cycle, so
  // remember that the write targeted this address and substitute it later.
  assign hit_d = we_eff_i && (w_addr_i == r_addr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= RF_ZERO_REG;
      hit_q  <= 1'b0;
      // Treated as "still sweeping" so the output reads zero under reset.
      init_q <= 1'b1;
    end else begin
      addr_q <= r_addr_i;
      hit_q  <= hit_d;
      init_q <= init_i;
    end
  end

  always_comb begin
    r_data_o = ram_dout_i;
    if (init_q || (addr_q == RF_ZERO_REG)) begin
      r_data_o = '0;
    end else if (hit_q) begin
      r_data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/rf_ctrl_3r1w.sv
// rtl/rf_ctrl_3r1w.sv - register-file controller: clear sweep, r0 protection, write forwarding
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   r_addr0..2 / r_data0..2    read ports, 1-cycle latency
//   w_en, w_addr, w_data       writeback port
//   ready                      high once every entry has been cleared
//   ram_addr0..2, ram_dout0..2 RAM read side (RAM registers its output)
//   ram_addrw, ram_din, ram_wea RAM write side, combinational
module rf_ctrl_3r1w
  import rf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = RF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  rf_addr_t         r_addr0,
  input  rf_addr_t         r_addr1,
  input  rf_addr_t         r_addr2,
  output logic [WIDTH-1:0] r_data0,
  output logic [WIDTH-1:0] r_data1,
  output logic [WIDTH-1:0] r_data2,
  input  logic             w_en,
  input  rf_addr_t         w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             ready,
  output rf_addr_t         ram_addr0,
  output rf_addr_t         ram_addr1,
  output rf_addr_t         ram_addr2,
  output rf_addr_t         ram_addrw,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_wea,
  input  logic [WIDTH-1:0] ram_dout0,
  input  logic [WIDTH-1:0] ram_dout1,
  input  logic [WIDTH-1:0] ram_dout2
);

  localparam rf_addr_t LAST_IDX = rf_addr_t'(DEPTH - 1);

  rf_state_e        state_q;
  rf_addr_t         clr_cnt_q;
  logic             ready_q;
  logic [WIDTH-1:0] byp_data_q;

  logic in_init;
  logic we_eff;

  assign in_init = (state_q == RF_INIT);
  // Writes are dropped during the sweep and never reach r0.
  assign we_eff  = !rst && (state_q == RF_RUN) && w_en && (w_addr != RF_ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RF_INIT;
      clr_cnt_q  <= RF_ZERO_REG;
      ready_q    <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_data_q <= w_data;
      case (state_q)
        RF_INIT: begin
          clr_cnt_q <= clr_cnt_q + 5'd1;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          state_q <= RF_RUN;
        end
        default: begin
          state_q <= RF_INIT;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign ram_addr0 = r_addr0;
  assign ram_addr1 = r_addr1;
  assign ram_addr2 = r_addr2;
  assign ram_wea   = (!rst && in_init) || we_eff;
  assign ram_addrw = in_init ? clr_cnt_q : w_addr;
  assign ram_din   = in_init ? '0 : w_data;

  rf_read_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk        (clk),
    .rst        (rst),
    .r_addr_i   (r_addr0),
    .init_i     (in_init),
    .we_eff_i   (we_eff),
    .w_addr_i   (w_addr),
    .byp_data_i (byp_data_q),
    .ram_dout_i (ram_dout0),
    .r_data_o   (r_data0)
  );

  rf_read_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .r_addr_i   (r_addr1),
    .init_i     (in_init),
    .we_eff_i   (we_eff),
    .w_addr_i   (w_addr),
    .byp_data_i (byp_data_q),
    .ram_dout_i (ram_dout1),
    .r_data_o   (r_data1)
  );

  rf_read_lane #(.WIDTH(WIDTH)) u_lane2 (
    .clk        (clk),
    .rst        (rst),
    .r_addr_i   (r_addr2),
    .init_i     (in_init),
    .we_eff_i   (we_eff),
    .w_addr_i   (w_addr),
    .byp_data_i (byp_data_q),
    .ram_dout_i (ram_dout2),
    .r_data_o   (r_data2)
  );

endmodule

// File: doc/rf_ctrl_3r1w.md
Name: rf_ctrl_3r1w

Overview:
- Register-file controller directly upstream of the 32-entry, 3-read/1-write register-file RAM.
- After reset, clears all 32 entries to zero with a sweep FSM and holds `ready` low until the sweep is done.
- Enforces architectural r0 = 0.
- Forwards a same-cycle write to any read port, because the RAM returns old data on read-during-write.
- Serves the decode/issue stage (3 read ports) and the writeback stage (1 write port).

Parameters:
- WIDTH, 32, data width of each register entry.
- DEPTH, 32, number of entries. Fixed; address width is 5.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- r_addr0  in  5  read port 0 address, cycle t
- r_addr1  in  5  read port 1 address, cycle t
- r_addr2  in  5  read port 2 address, cycle t
- r_data0  out  WIDTH  read port 0 data, cycle t+1
- r_data1  out  WIDTH  read port 1 data, cycle t+1
- r_data2  out  WIDTH  read port 2 data, cycle t+1
- w_en  in  1  writeback enable
- w_addr  in  5  writeback address
- w_data  in  WIDTH  writeback data
- ready  out  1  high once the clear sweep is complete
- ram_addr0, ram_addr1, ram_addr2  out  5 each  RAM read addresses
- ram_addrw  out  5  RAM write address
- ram_din  out  WIDTH  RAM write data
- ram_wea  out  1  RAM write enable
- ram_dout0, ram_dout1, ram_dout2  in  WIDTH each  RAM read data; registered in RAM, 1-cycle latency, old-data on read-during-write

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- States:
  - INIT: clear sweep in progress.
  - RUN: normal operation.
- While rst=1:
  - state<=INIT, clr_cnt<=0.
  - Registered outputs: ready=0, r_data0..2=0.
  - Bypass flags cleared.
  - ram_wea=0.
- INIT, rst=0:
  - ram_wea=1, ram_addrw=clr_cnt, ram_din=0; clr_cnt increments each cycle.
  - When clr_cnt==31 is written: state<=RUN next cycle, ready<=1.
  - First cycle with rst=0 is sweep cycle 0, so ready=1 in cycle 32.
- In INIT:
  - w_en is ignored, i.e. dropped, not queued.
  - r_data0..2 are forced to 0.
- RUN:
  - Effective write: we_eff = w_en && (w_addr != 0).
  - ram_wea=we_eff, ram_addrw=w_addr, ram_din=w_data.
  - Writes to r0 never reach the RAM.
- Read path (ports N = 0..2):
  - ram_addrN = r_addrN, combinational pass-through.
  - Registered in cycle t:
    - addr_qN <= r_addrN
    - hitN <= we_eff && (w_addr == r_addrN)
    - byp_data <= w_data, shared across the three ports
  - Output in cycle t+1, first matching rule wins:
    - state was INIT in cycle t: 0
    - addr_qN == 0: 0
    - hitN: byp_data
    - otherwise: ram_doutN
- Read latency is exactly 1 cycle on all ports, with no stall.
- Several ports may read the same address; all see identical data.
- A write in cycle t is visible to reads issued in cycle t (via bypass) and in all later cycles (via RAM).
- Reset mid-RUN: returns to INIT, ready drops the cycle after rst is sampled, and the full 32-cycle sweep restarts.
- Reset mid-INIT: clr_cnt restarts at 0.
- RAM-side outputs are combinational from state, clr_cnt and the inputs. No RAM output is registered in this block.

Decomposition:
- Shared package `rf_pkg`:
  - `rf_addr_t` (logic [4:0])
  - `RF_DEPTH` = 32
  - `RF_ZERO_REG` = 5'd0
  - enum `rf_state_e` {RF_INIT, RF_RUN}
- One natural sub-module, `rf_read_lane`, instantiated 3 times:
  - holds addr_q and hit flags, takes the shared byp_data register as an input;
  - implements the zero / bypass / RAM output mux.
- Top level holds the FSM, clr_cnt and the write gating.

Test Plan:
- Clear sweep: rst high 3 cycles then low; RAM model preloaded with 0xDEADBEEF. Expect:
  - ram_wea=1 with addrw 0..31 in cycles 0..31, ready=1 at cycle 32;
  - afterwards, reading r5 gives 0.
- Plain write/read: RUN, write r7=0x12345678 in cycle t; read r7 on port 1 in cycle t+1. Expect r_data1=0x12345678 in cycle t+2.
- Same-cycle bypass: write r3=0xA5A5A5A5 while all three ports read r3 in the same cycle. Expect all r_data=0xA5A5A5A5 next cycle, even though the RAM model returns the old value 0.
- r0 protection: write r0=0xFFFFFFFF. Expect:
  - ram_wea=0;
  - a same-cycle read of r0 gives 0 (no bypass);
  - a later read of r0 gives 0.
- Writes during INIT: w_en=1, w_addr=9, w_data=0x55 at sweep cycle 4. Expect:
  - ram_addrw=4, ram_din=0;
  - after ready, reading r9 gives 0.
- Reset mid-RUN: write r10=0x77, then assert rst for 1 cycle. Expect:
  - ready=0 the next cycle;
  - the sweep reruns, with ready back at 1 exactly 32 cycles after rst deasserts;
  - reading r10 then gives 0.
